// File: rtl/sram_controller.sv
`timescale 1ns/1ps
// Asynchronous SRAM access controller: one read or write at a time with WAIT_CYCLES extra strobe cycles.
// Optional byte-lane strobes (be, sram_ub, sram_lb) are built when SRAM_CTRL_BYTE_LANES_EN is defined.
module sram_controller #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] addr,
   input  logic [15:0] indata,
   input  logic        re,
   input  logic        we,
`ifdef SRAM_CTRL_BYTE_LANES_EN
   input  logic [1:0]  be,
   output logic        sram_ub,
   output logic        sram_lb,
`endif
   output logic [15:0] rdata,
   output logic        read_sync,
   output logic        write_sync,
   output logic        memclk,
   output logic [17:0] sram_addr,
   inout  wire  [15:0] sram_data,
   output logic        sram_ce,
   output logic        sram_re,
   output logic        sram_we
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ACCESS,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        drive_en;
   logic [15:0] wdata;

   // The bus enable is a register, so the data pins only ever toggle on clock edges or reset.
   assign sram_data = drive_en ? wdata : 16'hzzzz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         drive_en   <= 1'b0;
         sram_addr  <= 18'd0;
         rdata      <= 16'd0;
         read_sync  <= 1'b0;
         write_sync <= 1'b0;
         memclk     <= 1'b0;
         sram_ce    <= 1'b1;
         sram_re    <= 1'b1;
         sram_we    <= 1'b1;
`ifdef SRAM_CTRL_BYTE_LANES_EN
         sram_ub    <= 1'b1;
         sram_lb    <= 1'b1;
`endif
      end else begin
         read_sync  <= 1'b0;
         write_sync <= 1'b0;
         case (state)
            IDLE: begin
               // Read has priority; a held write is picked up on a later idle cycle.
               if (re) begin
                  state     <= RD_ACCESS;
                  wait_cnt  <= 4'd0;
                  sram_addr <= addr;
                  sram_ce   <= 1'b0;
                  sram_re   <= 1'b0;
                  memclk    <= 1'b1;
`ifdef SRAM_CTRL_BYTE_LANES_EN
                  sram_ub   <= ~be[1];
                  sram_lb   <= ~be[0];
`endif
               end else if (we) begin
                  state     <= WR_SETUP;
                  wait_cnt  <= 4'd0;
                  sram_addr <= addr;
                  sram_ce   <= 1'b0;
                  drive_en  <= 1'b1;
`ifdef SRAM_CTRL_BYTE_LANES_EN
                  sram_ub   <= ~be[1];
                  sram_lb   <= ~be[0];
`endif
               end
            end
            RD_ACCESS: begin
               if (wait_cnt == WAIT_LAST) begin
                  state     <= IDLE;
                  wait_cnt  <= 4'd0;
                  rdata     <= sram_data;
                  read_sync <= 1'b1;
                  sram_ce   <= 1'b1;
                  sram_re   <= 1'b1;
                  memclk    <= 1'b0;
`ifdef SRAM_CTRL_BYTE_LANES_EN
                  sram_ub   <= 1'b1;
                  sram_lb   <= 1'b1;
`endif
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            WR_SETUP: begin
               state    <= WR_PULSE;
               wait_cnt <= 4'd0;
               sram_we  <= 1'b0;
               memclk   <= 1'b1;
            end
            WR_PULSE: begin
               if (wait_cnt == WAIT_LAST) begin
                  state      <= WR_HOLD;
                  wait_cnt   <= 4'd0;
                  sram_we    <= 1'b1;
                  memclk     <= 1'b0;
                  write_sync <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            WR_HOLD: begin
               state    <= IDLE;
               wait_cnt <= 4'd0;
               drive_en <= 1'b0;
               sram_ce  <= 1'b1;
`ifdef SRAM_CTRL_BYTE_LANES_EN
               sram_ub  <= 1'b1;
               sram_lb  <= 1'b1;
`endif
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= 4'd0;
               drive_en <= 1'b0;
               sram_ce  <= 1'b1;
               sram_re  <= 1'b1;
               sram_we  <= 1'b1;
               memclk   <= 1'b0;
            end
         endcase
      end
   end

   // Write data is pure datapath: captured on acceptance, no reset needed.
   always_ff @(posedge clk) begin
      if (state == IDLE && !re && we) begin
         wdata <= indata;
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
// Bench for sram_controller (WAIT_CYCLES=1) with a small behavioural SRAM and rdata/write scoreboards.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [17:0] addr = 18'd0;
   logic [15:0] indata = 16'd0;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [15:0] rdata;
   logic        read_sync, write_sync, memclk;
   logic [17:0] sram_addr;
   wire  [15:0] sram_data;
   logic        sram_ce, sram_re, sram_we;
`ifdef SRAM_CTRL_BYTE_LANES_EN
   logic [1:0]  be = 2'b11;
   logic        sram_ub, sram_lb;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] rd_q[$];
   logic [33:0] wr_q[$];

   sram_controller #(.WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .addr(addr), .indata(indata), .re(re), .we(we),
`ifdef SRAM_CTRL_BYTE_LANES_EN
      .be(be), .sram_ub(sram_ub), .sram_lb(sram_lb),
`endif
      .rdata(rdata), .read_sync(read_sync), .write_sync(write_sync), .memclk(memclk),
      .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce(sram_ce),
      .sram_re(sram_re), .sram_we(sram_we)
   );

   always #5 clk = ~clk;

   // SRAM model: 16 words by addr[3:0]; unwritten words read as 0x100<n>.
   logic [15:0] mem [16];
   logic [15:0] written = 16'd0;
   logic [15:0] mdata;
   assign mdata = written[sram_addr[3:0]] ? mem[sram_addr[3:0]] : {12'h100, sram_addr[3:0]};
   assign sram_data = (!sram_ce && !sram_re) ? mdata : 16'hzzzz;
   always @(posedge sram_we) begin
      if (rst && !sram_ce) begin
         mem[sram_addr[3:0]] = sram_data;
         written[sram_addr[3:0]] = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("memclk_vs_strobes", {31'b0, memclk}, {31'b0, (~sram_re | ~sram_we)});
         chk("strobe_overlap", {31'b0, (!sram_re && !sram_we)}, 32'd0);
         if (read_sync) begin
            if (rd_q.size() == 0) chk("unexpected_read_sync", 32'd1, 32'd0);
            else chk("sb_rdata", {16'h0, rdata}, {16'h0, rd_q.pop_front()});
         end
         if (write_sync) begin
            if (wr_q.size() == 0) chk("unexpected_write_sync", 32'd1, 32'd0);
            else begin
               logic [33:0] e;
               e = wr_q.pop_front();
               chk("sb_wr_addr", {14'h0, sram_addr}, {14'h0, e[33:16]});
               chk("sb_wr_data", {16'h0, sram_data}, {16'h0, e[15:0]});
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_ce"}, {31'b0, sram_ce}, 32'd1);
      chk({tag, "_re"}, {31'b0, sram_re}, 32'd1);
      chk({tag, "_we"}, {31'b0, sram_we}, 32'd1);
      chk({tag, "_memclk"}, {31'b0, memclk}, 32'd0);
      chk({tag, "_addr"}, {14'h0, sram_addr}, 32'd0);
      chk({tag, "_rdata"}, {16'h0, rdata}, 32'd0);
      chk({tag, "_syncs"}, {30'b0, read_sync, write_sync}, 32'd0);
      chk({tag, "_bus"}, {16'h0, sram_data}, {16'h0, 16'hzzzz});
`ifdef SRAM_CTRL_BYTE_LANES_EN
      chk({tag, "_lanes"}, {30'b0, sram_ub, sram_lb}, 32'd3);
`endif
   endtask

   // Cycle-exact write; entered and left on a negedge with the controller idle.
   task automatic write_timed(input logic [17:0] a, input logic [15:0] d);
      wr_q.push_back({a, d});
      addr = a; indata = d; we = 1'b1;
`ifdef SRAM_CTRL_BYTE_LANES_EN
      be = 2'b01;
`endif
      @(negedge clk);
      we = 1'b0; addr = 18'h2AAAA; indata = 16'h0F0F;
`ifdef SRAM_CTRL_BYTE_LANES_EN
      be = 2'b10;
      chk("wr_lanes", {30'b0, sram_ub, sram_lb}, 32'd2);
`endif
      chk("wr_setup_we", {31'b0, sram_we}, 32'd1);
      chk("wr_setup_ce", {31'b0, sram_ce}, 32'd0);
      chk("wr_setup_bus", {16'h0, sram_data}, {16'h0, d});
      chk("wr_setup_addr", {14'h0, sram_addr}, {14'h0, a});
      chk("wr_setup_sync", {31'b0, write_sync}, 32'd0);
      @(negedge clk);
      chk("wr_pulse1_we", {31'b0, sram_we}, 32'd0);
      chk("wr_pulse1_bus", {16'h0, sram_data}, {16'h0, d});
      @(negedge clk);
      chk("wr_pulse2_we", {31'b0, sram_we}, 32'd0);
      chk("wr_pulse2_sync", {31'b0, write_sync}, 32'd0);
      @(negedge clk);
      chk("wr_hold_we", {31'b0, sram_we}, 32'd1);
      chk("wr_hold_ce", {31'b0, sram_ce}, 32'd0);
      chk("wr_hold_sync", {31'b0, write_sync}, 32'd1);
      chk("wr_hold_bus", {16'h0, sram_data}, {16'h0, d});
      @(negedge clk);
      chk("wr_idle_ce", {31'b0, sram_ce}, 32'd1);
      chk("wr_idle_bus", {16'h0, sram_data}, {16'h0, 16'hzzzz});
      chk("wr_idle_sync", {31'b0, write_sync}, 32'd0);
      chk("wr_idle_addr", {14'h0, sram_addr}, {14'h0, a});
`ifdef SRAM_CTRL_BYTE_LANES_EN
      chk("wr_idle_lanes", {30'b0, sram_ub, sram_lb}, 32'd3);
`endif
   endtask

   task automatic read_timed(input logic [17:0] a, input logic [15:0] exp);
      rd_q.push_back(exp);
      addr = a; re = 1'b1;
      @(negedge clk);
      re = 1'b0; addr = 18'h15555;
      chk("rd_acc1_re", {31'b0, sram_re}, 32'd0);
      chk("rd_acc1_ce", {31'b0, sram_ce}, 32'd0);
      chk("rd_acc1_we", {31'b0, sram_we}, 32'd1);
      chk("rd_acc1_sync", {31'b0, read_sync}, 32'd0);
      @(negedge clk);
      chk("rd_acc2_re", {31'b0, sram_re}, 32'd0);
      @(negedge clk);
      chk("rd_done_sync", {31'b0, read_sync}, 32'd1);
      chk("rd_done_data", {16'h0, rdata}, {16'h0, exp});
      chk("rd_done_strobes", {30'b0, sram_ce, sram_re}, 32'd3);
      @(negedge clk);
      chk("rd_after_sync", {31'b0, read_sync}, 32'd0);
      chk("rd_after_data", {16'h0, rdata}, {16'h0, exp});
   endtask

   typedef struct {
      bit          wr;
      logic [17:0] a;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   task automatic do_op(input vec_t v);
      int n;
      bit got;
      n = 0; got = 1'b0;
      addr = v.a; indata = v.d;
      if (v.wr) begin wr_q.push_back({v.a, v.d}); we = 1'b1; end
      else begin rd_q.push_back(v.exp); re = 1'b1; end
      @(negedge clk);
      re = 1'b0; we = 1'b0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (v.wr ? write_sync : read_sync) begin got = 1'b1; n = 40; end
      end
      if (!got) chk("op_timeout", 32'd1, 32'd0);
      if (v.wr) @(negedge clk);
   endtask

   vec_t vecs[11];

   initial begin
      int cyc, last, nrd, nwr;
      vecs[0]  = '{1'b1, 18'h00005, 16'hBEEF, 16'h0000};
      vecs[1]  = '{1'b0, 18'h00005, 16'h0000, 16'hBEEF};
      vecs[2]  = '{1'b1, 18'h3FFFF, 16'h1234, 16'h0000};
      vecs[3]  = '{1'b1, 18'h00000, 16'hA5A5, 16'h0000};
      vecs[4]  = '{1'b0, 18'h3FFFF, 16'h0000, 16'h1234};
      vecs[5]  = '{1'b0, 18'h00000, 16'h0000, 16'hA5A5};
      vecs[6]  = '{1'b1, 18'h0000A, 16'hFFFF, 16'h0000};
      vecs[7]  = '{1'b0, 18'h0000A, 16'h0000, 16'hFFFF};
      vecs[8]  = '{1'b1, 18'h0000A, 16'h0000, 16'h0000};
      vecs[9]  = '{1'b0, 18'h0000A, 16'h0000, 16'h0000};
      vecs[10] = '{1'b0, 18'h00003, 16'h0000, 16'h1003};

      #2 rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      write_timed(18'h00005, 16'hBEEF);
      read_timed(18'h00005, 16'hBEEF);

      for (int i = 0; i < 11; i++) do_op(vecs[i]);

      // re and we held together: only reads, one every three cycles.
      for (int k = 0; k < 4; k++) rd_q.push_back(16'h1234);
      addr = 18'h3FFFF; indata = 16'hDEAD; re = 1'b1; we = 1'b1;
      cyc = 0; last = -1; nrd = 0; nwr = 0;
      while (nrd < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (write_sync) nwr++;
         if (read_sync) begin
            if (last >= 0) chk("rw_period", cyc - last, 32'd3);
            else chk("rw_first_latency", cyc, 32'd3);
            last = cyc;
            nrd++;
         end
      end
      re = 1'b0; we = 1'b0;
      chk("rw_reads", nrd, 32'd4);
      chk("rw_no_write", nwr, 32'd0);
      @(negedge clk);

      // Reset asserted in the middle of the write strobe.
      addr = 18'h00007; indata = 16'h7777; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
      @(negedge clk);
      chk("midrst_in_pulse", {31'b0, sram_we}, 32'd0);
      #2 rst = 1'b0;
      #1 check_reset_state("midrst_async");
      repeat (2) @(negedge clk);
      check_reset_state("midrst_held");
      rst = 1'b1;
      write_timed(18'h00009, 16'h5A5A);
      read_timed(18'h00009, 16'h5A5A);
      read_timed(18'h00007, 16'h1007);

      repeat (3) @(negedge clk);
      chk("rd_q_drained", rd_q.size(), 32'd0);
      chk("wr_q_drained", wr_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
